// File: rtl/lazy_summary_if.sv
// -----------------------------------------------------------------------------
// lazy_summary_if
// Bundles the match-result inputs and the LZ-sequence summary outputs of
// lazy_summary_stage.
//   master : producer side (drives i_*, observes o_*)
//   slave  : lazy_summary_stage side (reads i_*, drives o_*)
// Inputs : i_match_done, i_match_head_ptr, i_seq_head_ptr, i_delim,
//          i_match_valid[L], i_match_len[L*MATCH_LEN_WIDTH],
//          i_offset[L*SEQ_OFFSET_BITS]
// Outputs: o_summary_done, o_seq_head_ptr, o_summary_ll, o_summary_ml,
//          o_summary_offset, o_summary_eoj, o_summary_overlap_len,
//          o_summary_delim, o_move_to_next_job, o_move_forward
// -----------------------------------------------------------------------------
interface lazy_summary_if #(
   parameter int unsigned LAZY_MATCH_LEN  = 4,
   parameter int unsigned JOB_LEN_LOG2    = 5,
   parameter int unsigned MATCH_LEN_WIDTH = 8,
   parameter int unsigned SEQ_LL_BITS     = 8,
   parameter int unsigned SEQ_ML_BITS     = 8,
   parameter int unsigned SEQ_OFFSET_BITS = 16
);
   logic                                        i_match_done;
   logic [JOB_LEN_LOG2-1:0]                     i_match_head_ptr;
   logic [JOB_LEN_LOG2-1:0]                     i_seq_head_ptr;
   logic                                        i_delim;
   logic [LAZY_MATCH_LEN-1:0]                   i_match_valid;
   logic [LAZY_MATCH_LEN*MATCH_LEN_WIDTH-1:0]   i_match_len;
   logic [LAZY_MATCH_LEN*SEQ_OFFSET_BITS-1:0]   i_offset;

   logic                                        o_summary_done;
   logic [JOB_LEN_LOG2-1:0]                     o_seq_head_ptr;
   logic [SEQ_LL_BITS-1:0]                      o_summary_ll;
   logic [SEQ_ML_BITS-1:0]                      o_summary_ml;
   logic [SEQ_OFFSET_BITS-1:0]                  o_summary_offset;
   logic                                        o_summary_eoj;
   logic [SEQ_ML_BITS-1:0]                      o_summary_overlap_len;
   logic                                        o_summary_delim;
   logic                                        o_move_to_next_job;
   logic [JOB_LEN_LOG2-1:0]                     o_move_forward;

   modport master (
      output i_match_done, i_match_head_ptr, i_seq_head_ptr, i_delim,
             i_match_valid, i_match_len, i_offset,
      input  o_summary_done, o_seq_head_ptr, o_summary_ll, o_summary_ml,
             o_summary_offset, o_summary_eoj, o_summary_overlap_len,
             o_summary_delim, o_move_to_next_job, o_move_forward
   );

   modport slave (
      input  i_match_done, i_match_head_ptr, i_seq_head_ptr, i_delim,
             i_match_valid, i_match_len, i_offset,
      output o_summary_done, o_seq_head_ptr, o_summary_ll, o_summary_ml,
             o_summary_offset, o_summary_eoj, o_summary_overlap_len,
             o_summary_delim, o_move_to_next_job, o_move_forward
   );
endinterface

// File: rtl/lazy_summary_stage.sv
// -----------------------------------------------------------------------------
// lazy_summary_stage
// Two-stage lazy-match arbiter. Stage 1 scores every candidate position
// (gain = 4*len - flog2(offset) - index); stage 2 picks the eligible candidate
// with the highest gain (lowest index on ties) and forms one LZ sequence plus
// the sequence-head advance. Latency is 2 cycles, a new result every cycle.
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : lazy_summary_if.slave (match inputs in, summary outputs out)
// -----------------------------------------------------------------------------
module lazy_summary_stage #(
   parameter int unsigned LAZY_MATCH_LEN  = 4,
   parameter int unsigned JOB_LEN_LOG2    = 5,
   parameter int unsigned MATCH_LEN_WIDTH = 8,
   parameter int unsigned SEQ_LL_BITS     = 8,
   parameter int unsigned SEQ_ML_BITS     = 8,
   parameter int unsigned SEQ_OFFSET_BITS = 16
) (
   input  logic            clk,
   input  logic            rst,
   lazy_summary_if.slave   bus
);
   localparam int unsigned L       = LAZY_MATCH_LEN;
   localparam int unsigned MW      = MATCH_LEN_WIDTH;
   localparam int unsigned OW      = SEQ_OFFSET_BITS;
   localparam int unsigned JW      = JOB_LEN_LOG2;
   localparam int unsigned GW      = MATCH_LEN_WIDTH + 3;
   localparam int unsigned PW      = JOB_LEN_LOG2 + 1;
   localparam int unsigned EW      = JOB_LEN_LOG2 + MATCH_LEN_WIDTH + 1;
   localparam int unsigned FW      = (OW > 1) ? $clog2(OW) : 1;
   localparam int unsigned KW      = (L > 1) ? $clog2(L) : 1;
   localparam int unsigned JOB_LEN = 1 << JOB_LEN_LOG2;

   // Index of the highest set bit; 0 and 1 both map to 0.
   function automatic logic [FW-1:0] flog2(input logic [OW-1:0] v);
      flog2 = '0;
      for (int unsigned b = 0; b < OW; b++) begin
         if (v[b]) flog2 = FW'(b);
      end
   endfunction

   // Lowest-index priority selector: one-hot of the lowest set bit.
   function automatic logic [L-1:0] prio_lowest(input logic [L-1:0] v);
      logic found;
      prio_lowest = '0;
      found       = 1'b0;
      for (int unsigned b = 0; b < L; b++) begin
         if (v[b] && !found) begin
            prio_lowest[b] = 1'b1;
            found          = 1'b1;
         end
      end
   endfunction

   // ---------------------------------------------------------------- stage 1
   logic                 [MW-1:0] w_len  [L];
   logic                 [OW-1:0] w_off  [L];
   logic signed          [GW-1:0] w_gain [L];

   always_comb begin
      for (int unsigned i = 0; i < L; i++) begin
         w_len[i]  = bus.i_match_len[i*MW +: MW];
         w_off[i]  = bus.i_offset[i*OW +: OW];
         // Arithmetic is mod 2^GW; the signed view gives the true gain.
         w_gain[i] = {1'b0, w_len[i], 2'b00} - GW'(flog2(w_off[i])) - GW'(i);
      end
   end

   logic                 r_s1_valid;
   logic [JW-1:0]        r_s1_mhead;
   logic [JW-1:0]        r_s1_shead;
   logic                 r_s1_delim;
   logic [L-1:0]         r_s1_vmask;
   logic signed [GW-1:0] r_s1_gain [L];
   logic [MW-1:0]        r_s1_len  [L];
   logic [OW-1:0]        r_s1_off  [L];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_mhead <= '0;
         r_s1_shead <= '0;
         r_s1_delim <= 1'b0;
         r_s1_vmask <= '0;
         for (int unsigned i = 0; i < L; i++) begin
            r_s1_gain[i] <= '0;
            r_s1_len[i]  <= '0;
            r_s1_off[i]  <= '0;
         end
      end else begin
         r_s1_valid <= bus.i_match_done;
         r_s1_mhead <= bus.i_match_head_ptr;
         r_s1_shead <= bus.i_seq_head_ptr;
         r_s1_delim <= bus.i_delim;
         r_s1_vmask <= bus.i_match_valid;
         for (int unsigned i = 0; i < L; i++) begin
            r_s1_gain[i] <= w_gain[i];
            r_s1_len[i]  <= w_len[i];
            r_s1_off[i]  <= w_off[i];
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [L-1:0]          w_win;
   logic [L-1:0]          w_sel;
   logic [KW-1:0]         w_k;
   logic [MW-1:0]         w_len_k;
   logic [OW-1:0]         w_off_k;
   logic [PW-1:0]         w_pos;
   logic [EW-1:0]         w_end;
   logic [SEQ_LL_BITS-1:0] w_ll;
   logic [SEQ_ML_BITS-1:0] w_ml;
   logic [OW-1:0]         w_offv;
   logic                  w_eoj;
   logic [SEQ_ML_BITS-1:0] w_ovl;
   logic [JW-1:0]         w_mf;

   always_comb begin
      // A candidate wins when eligible and no eligible candidate beats it.
      w_win = '0;
      for (int unsigned i = 0; i < L; i++) begin
         w_win[i] = r_s1_vmask[i];
         for (int unsigned j = 0; j < L; j++) begin
            if (r_s1_vmask[j] && (r_s1_gain[j] > r_s1_gain[i])) w_win[i] = 1'b0;
         end
      end
      w_sel = prio_lowest(w_win);

      // One-hot OR mux for payloads and the selected index.
      w_len_k = '0;
      w_off_k = '0;
      w_k     = '0;
      for (int unsigned i = 0; i < L; i++) begin
         w_len_k = w_len_k | (r_s1_len[i] & {MW{w_sel[i]}});
         w_off_k = w_off_k | (r_s1_off[i] & {OW{w_sel[i]}});
         w_k     = w_k     | (KW'(i)      & {KW{w_sel[i]}});
      end

      w_pos = PW'(r_s1_mhead) + PW'(w_k);
      w_end = EW'(w_pos) + EW'(w_len_k);

      if (|r_s1_vmask) begin
         w_ll   = SEQ_LL_BITS'(w_pos) - SEQ_LL_BITS'(r_s1_shead);
         w_ml   = SEQ_ML_BITS'(w_len_k);
         w_offv = w_off_k;
         w_eoj  = (w_end >= EW'(JOB_LEN));
         w_ovl  = w_eoj ? SEQ_ML_BITS'(w_end - EW'(JOB_LEN)) : '0;
      end else begin
         // Literal fallback: consume one more literal at the match head.
         w_ll   = SEQ_LL_BITS'(r_s1_mhead) - SEQ_LL_BITS'(r_s1_shead) + SEQ_LL_BITS'(1);
         w_ml   = '0;
         w_offv = '0;
         w_eoj  = (r_s1_mhead == JW'(JOB_LEN - 1));
         w_ovl  = '0;
      end
      w_mf = JW'(w_ll) + JW'(w_ml);
   end

   logic                   r_done;
   logic [JW-1:0]          r_shead;
   logic [SEQ_LL_BITS-1:0] r_ll;
   logic [SEQ_ML_BITS-1:0] r_ml;
   logic [OW-1:0]          r_off;
   logic                   r_eoj;
   logic [SEQ_ML_BITS-1:0] r_ovl;
   logic                   r_delim;
   logic [JW-1:0]          r_mf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_done  <= 1'b0;
         r_shead <= '0;
         r_ll    <= '0;
         r_ml    <= '0;
         r_off   <= '0;
         r_eoj   <= 1'b0;
         r_ovl   <= '0;
         r_delim <= 1'b0;
         r_mf    <= '0;
      end else begin
         r_done  <= r_s1_valid;
         r_shead <= r_s1_shead;
         r_ll    <= w_ll;
         r_ml    <= w_ml;
         r_off   <= w_offv;
         r_eoj   <= w_eoj;
         r_ovl   <= w_ovl;
         r_delim <= r_s1_delim & w_eoj;
         r_mf    <= w_mf;
      end
   end

   assign bus.o_summary_done        = r_done;
   assign bus.o_seq_head_ptr        = r_shead;
   assign bus.o_summary_ll          = r_ll;
   assign bus.o_summary_ml          = r_ml;
   assign bus.o_summary_offset      = r_off;
   assign bus.o_summary_eoj         = r_eoj;
   assign bus.o_summary_overlap_len = r_ovl;
   assign bus.o_summary_delim       = r_delim;
   assign bus.o_move_to_next_job    = r_eoj;
   assign bus.o_move_forward        = r_mf;

endmodule

// File: tb/tb_lazy_summary_stage.sv
// -----------------------------------------------------------------------------
// tb_lazy_summary_stage
// Self-checking bench for lazy_summary_stage: a table of directed vectors with
// hand-computed sequences, plus hand-written done-pulse and reset sequences.
// -----------------------------------------------------------------------------
module tb_lazy_summary_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   lazy_summary_if bus ();

   lazy_summary_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [4:0]  sh;
      logic [4:0]  mh;
      logic        dl;
      logic [3:0]  v;
      logic [31:0] lens;   // {len3, len2, len1, len0}
      logic [63:0] offs;   // {off3, off2, off1, off0}
      logic [7:0]  e_ll;
      logic [7:0]  e_ml;
      logic [15:0] e_off;
      logic        e_eoj;
      logic [7:0]  e_ovl;
      logic        e_dl;
      logic [4:0]  e_mf;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".done"},  32'(bus.o_summary_done), 32'd0);
      check({tag, ".sh"},    32'(bus.o_seq_head_ptr), 32'd0);
      check({tag, ".ll"},    32'(bus.o_summary_ll), 32'd0);
      check({tag, ".ml"},    32'(bus.o_summary_ml), 32'd0);
      check({tag, ".off"},   32'(bus.o_summary_offset), 32'd0);
      check({tag, ".eoj"},   32'(bus.o_summary_eoj), 32'd0);
      check({tag, ".ovl"},   32'(bus.o_summary_overlap_len), 32'd0);
      check({tag, ".delim"}, 32'(bus.o_summary_delim), 32'd0);
      check({tag, ".mnj"},   32'(bus.o_move_to_next_job), 32'd0);
      check({tag, ".mf"},    32'(bus.o_move_forward), 32'd0);
   endtask

   task automatic drive(input vec_t t, input logic done);
      bus.i_match_done     = done;
      bus.i_seq_head_ptr   = t.sh;
      bus.i_match_head_ptr = t.mh;
      bus.i_delim          = t.dl;
      bus.i_match_valid    = t.v;
      bus.i_match_len      = t.lens;
      bus.i_offset         = t.offs;
   endtask

   initial begin
      // single candidate
      vecs[0]  = '{5'd0,  5'd2,  1'b0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd6},
                   {16'd0, 16'd0, 16'd0, 16'd8},
                   8'd2,  8'd6,  16'd8,    1'b0, 8'd0,   1'b0, 5'd8};
      // lazy win: candidate 1 (gain 21) beats candidate 0 (gain 12)
      vecs[1]  = '{5'd0,  5'd3,  1'b0, 4'b0011, {8'd0, 8'd0, 8'd8, 8'd4},
                   {16'd0, 16'd0, 16'd1024, 16'd16},
                   8'd4,  8'd8,  16'd1024, 1'b0, 8'd0,   1'b0, 5'd12};
      // tie at gain 18: candidate 0
      vecs[2]  = '{5'd0,  5'd3,  1'b0, 4'b0011, {8'd0, 8'd0, 8'd5, 8'd5},
                   {16'd0, 16'd0, 16'd2, 16'd4},
                   8'd3,  8'd5,  16'd4,    1'b0, 8'd0,   1'b0, 5'd8};
      // job overflow with delimiter
      vecs[3]  = '{5'd20, 5'd28, 1'b1, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd10},
                   {16'd0, 16'd0, 16'd0, 16'd100},
                   8'd8,  8'd10, 16'd100,  1'b1, 8'd6,   1'b1, 5'd18};
      // no eligible candidate at last job position, payloads ignored
      vecs[4]  = '{5'd29, 5'd31, 1'b1, 4'b0000, {8'd9, 8'd9, 8'd9, 8'd9},
                   {16'd7, 16'd7, 16'd7, 16'd7},
                   8'd3,  8'd0,  16'd0,    1'b1, 8'd0,   1'b1, 5'd3};
      // invalid long candidate 0 ignored, candidate 2 chosen
      vecs[5]  = '{5'd5,  5'd10, 1'b0, 4'b0100, {8'd0, 8'd3, 8'd0, 8'd50},
                   {16'd0, 16'd0, 16'd0, 16'd1},
                   8'd7,  8'd3,  16'd0,    1'b0, 8'd0,   1'b0, 5'd10};
      // highest index wins on gain
      vecs[6]  = '{5'd0,  5'd0,  1'b0, 4'b1111, {8'd9, 8'd1, 8'd1, 8'd1},
                   {16'd1, 16'd1, 16'd1, 16'd1},
                   8'd3,  8'd9,  16'd1,    1'b0, 8'd0,   1'b0, 5'd12};
      // end lands exactly on JOB_LEN, delim input low
      vecs[7]  = '{5'd16, 5'd30, 1'b0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd2},
                   {16'd0, 16'd0, 16'd0, 16'd1},
                   8'd14, 8'd2,  16'd1,    1'b1, 8'd0,   1'b0, 5'd16};
      // literal fallback mid-job
      vecs[8]  = '{5'd4,  5'd10, 1'b1, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0},
                   {16'd0, 16'd0, 16'd0, 16'd0},
                   8'd7,  8'd0,  16'd0,    1'b0, 8'd0,   1'b0, 5'd7};
      // large offset penalty: candidate 0 (gain 20) over candidate 1 (gain 8)
      vecs[9]  = '{5'd1,  5'd1,  1'b0, 4'b0011, {8'd0, 8'd0, 8'd6, 8'd5},
                   {16'd0, 16'd0, 16'd65535, 16'd1},
                   8'd0,  8'd5,  16'd1,    1'b0, 8'd0,   1'b0, 5'd5};
      // long match: overlap 188, move_forward 220 mod 32
      vecs[10] = '{5'd0,  5'd20, 1'b0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd200},
                   {16'd0, 16'd0, 16'd0, 16'd3},
                   8'd20, 8'd200, 16'd3,   1'b1, 8'd188, 1'b0, 5'd28};

      drive(vecs[0], 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // table-driven vectors, done held high throughout
      for (int n = 0; n < 11; n++) begin
         @(negedge clk);
         drive(vecs[n], 1'b1);
         @(posedge clk);
         @(posedge clk);
         #1;
         check($sformatf("v%0d.done", n),  32'(bus.o_summary_done), 32'd1);
         check($sformatf("v%0d.sh", n),    32'(bus.o_seq_head_ptr), 32'(vecs[n].sh));
         check($sformatf("v%0d.ll", n),    32'(bus.o_summary_ll), 32'(vecs[n].e_ll));
         check($sformatf("v%0d.ml", n),    32'(bus.o_summary_ml), 32'(vecs[n].e_ml));
         check($sformatf("v%0d.off", n),   32'(bus.o_summary_offset), 32'(vecs[n].e_off));
         check($sformatf("v%0d.eoj", n),   32'(bus.o_summary_eoj), 32'(vecs[n].e_eoj));
         check($sformatf("v%0d.ovl", n),   32'(bus.o_summary_overlap_len), 32'(vecs[n].e_ovl));
         check($sformatf("v%0d.delim", n), 32'(bus.o_summary_delim), 32'(vecs[n].e_dl));
         check($sformatf("v%0d.mnj", n),   32'(bus.o_move_to_next_job), 32'(vecs[n].e_eoj));
         check($sformatf("v%0d.mf", n),    32'(bus.o_move_forward), 32'(vecs[n].e_mf));
      end

      // done pulse of 3 cycles appears 2 cycles later, also 3 cycles long
      @(negedge clk);
      bus.i_match_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle.done", 32'(bus.o_summary_done), 32'd0);
      @(negedge clk);
      bus.i_match_done = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("pulse.c%0d", c), 32'(bus.o_summary_done),
               (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
         if (c == 3) begin
            @(negedge clk);
            bus.i_match_done = 1'b0;
         end
      end

      // reset asserted mid-operation clears everything next cycle
      @(negedge clk);
      drive(vecs[3], 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst.eoj", 32'(bus.o_summary_eoj), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst.c1.done", 32'(bus.o_summary_done), 32'd0);
      @(posedge clk);
      #1;
      check("post_rst.c2.done", 32'(bus.o_summary_done), 32'd1);
      check("post_rst.c2.ovl",  32'(bus.o_summary_overlap_len), 32'd6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
